// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: widths, opcodes, NOP, execute bundle and operand resolution.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = $clog2(NREGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Payload handed from decode to execute
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   instr;
    logic [REG_AW-1:0] rd_sel;
    logic              write_enable;
    logic [XLEN-1:0]   rs1_value;
    logic [XLEN-1:0]   rs2_value;
  } ex_bundle_t;

  // Opcodes whose instructions write rd
  function automatic logic opcode_writes_rd(input logic [6:0] opcode);
    logic w;
    w = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: w = 1'b1;
      default:                      w = 1'b0;
    endcase
    return w;
  endfunction

  // Source operand select: x0, then execute forward, then write-back bypass, then register file
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf_data,
    input logic              fwd_en,
    input logic [REG_AW-1:0] fwd_rd,
    input logic [XLEN-1:0]   fwd_value,
    input logic              wb_en,
    input logic [REG_AW-1:0] wb_rd,
    input logic [XLEN-1:0]   wb_value
  );
    logic [XLEN-1:0] v;
    if (rs == '0)                        v = '0;
    else if (fwd_en && (fwd_rd == rs))   v = fwd_value;
    else if (wb_en && (wb_rd == rs))     v = wb_value;
    else                                 v = rf_data;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_reg_decode_if.sv
// Decode stage bus: fetch input, write-back and execute-forward ports, execute-side output bundle.
interface pipeline_reg_decode_if;
  import rv_pkg::*;

  logic                instr_valid;
  logic [XLEN-1:0]     instr;
  logic                stall;
  logic                flush;
  logic                wb_write_enable;
  logic [REG_AW-1:0]   wb_rd_sel;
  logic [XLEN-1:0]     wb_value;
  logic                ex_fwd_enable;
  logic [REG_AW-1:0]   ex_fwd_rd;
  logic [XLEN-1:0]     ex_fwd_value;
  logic                ex_valid;
  logic [XLEN-1:0]     ex_instr;
  logic [REG_AW-1:0]   ex_rd_sel;
  logic                ex_write_enable;
  logic [XLEN-1:0]     ex_rs1_value;
  logic [XLEN-1:0]     ex_rs2_value;

  modport master (
    output instr_valid, instr, stall, flush,
    output wb_write_enable, wb_rd_sel, wb_value,
    output ex_fwd_enable, ex_fwd_rd, ex_fwd_value,
    input  ex_valid, ex_instr, ex_rd_sel, ex_write_enable, ex_rs1_value, ex_rs2_value
  );

  modport slave (
    input  instr_valid, instr, stall, flush,
    input  wb_write_enable, wb_rd_sel, wb_value,
    input  ex_fwd_enable, ex_fwd_rd, ex_fwd_value,
    output ex_valid, ex_instr, ex_rd_sel, ex_write_enable, ex_rs1_value, ex_rs2_value
  );
endinterface

// File: rtl/pipeline_reg_decode_reg_file.sv
// Integer register file: two combinational reads, one synchronous write, x0 reads zero.
module reg_file
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_a,
  output logic [XLEN-1:0]   rd_data_a_c,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [XLEN-1:0]   rd_data_b_c,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  logic [XLEN-1:0] regs [NREGS];

  // Clear on reset; write port discards x0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a_c = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
  assign rd_data_b_c = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/pipeline_reg_decode.sv
// Decode-to-execute stage: register file, operand forwarding and the execute pipeline register.
module pipeline_reg_decode
  import rv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  pipeline_reg_decode_if.slave bus
);

  ex_bundle_t        ex_q;
  ex_bundle_t        ex_d;
  logic [REG_AW-1:0] rs1_sel;
  logic [REG_AW-1:0] rs2_sel;
  logic [XLEN-1:0]   rf_rs1;
  logic [XLEN-1:0]   rf_rs2;
  logic [XLEN-1:0]   rs1_res;
  logic [XLEN-1:0]   rs2_res;
  logic              dec_write_enable;

  // During a stall the held instruction's sources are re-read so operands follow late write-backs
  always_comb begin
    rs1_sel = bus.stall ? ex_q.instr[19:15] : bus.instr[19:15];
    rs2_sel = bus.stall ? ex_q.instr[24:20] : bus.instr[24:20];
  end

  reg_file u_reg_file (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_a   (rs1_sel),
    .rd_data_a_c (rf_rs1),
    .rd_addr_b   (rs2_sel),
    .rd_data_b_c (rf_rs2),
    .wr_en       (bus.wb_write_enable),
    .wr_addr     (bus.wb_rd_sel),
    .wr_data     (bus.wb_value)
  );

  // Operand resolution and write-intent decode
  always_comb begin
    rs1_res = resolve_operand(rs1_sel, rf_rs1, bus.ex_fwd_enable, bus.ex_fwd_rd,
                              bus.ex_fwd_value, bus.wb_write_enable, bus.wb_rd_sel, bus.wb_value);
    rs2_res = resolve_operand(rs2_sel, rf_rs2, bus.ex_fwd_enable, bus.ex_fwd_rd,
                              bus.ex_fwd_value, bus.wb_write_enable, bus.wb_rd_sel, bus.wb_value);
    dec_write_enable = bus.instr_valid && (bus.instr[11:7] != '0) &&
                       opcode_writes_rd(bus.instr[6:0]);
  end

  // Next execute bundle: flush over stall over normal capture
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d       = '0;
      ex_d.instr = NOP_INSTR;
    end else if (bus.stall) begin
      ex_d.rs1_value = rs1_res;
      ex_d.rs2_value = rs2_res;
    end else begin
      ex_d.valid        = bus.instr_valid;
      ex_d.instr        = bus.instr;
      ex_d.rd_sel       = bus.instr[11:7];
      ex_d.write_enable = dec_write_enable;
      ex_d.rs1_value    = rs1_res;
      ex_d.rs2_value    = rs2_res;
    end
  end

  // Execute pipeline register
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_instr        = ex_q.instr;
  assign bus.ex_rd_sel       = ex_q.rd_sel;
  assign bus.ex_write_enable = ex_q.write_enable;
  assign bus.ex_rs1_value    = ex_q.rs1_value;
  assign bus.ex_rs2_value    = ex_q.rs2_value;

endmodule

// File: tb/tb_pipeline_reg_decode.sv
// Bench for pipeline_reg_decode: directed scenarios plus random traffic against a reference model.
module tb_pipeline_reg_decode;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pipeline_reg_decode_if bus ();

  pipeline_reg_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: architectural registers and the expected execute bundle
  logic [31:0] mregs [32];
  logic        e_valid;
  logic [31:0] e_instr;
  logic [4:0]  e_rd;
  logic        e_we;
  logic [31:0] e_rs1;
  logic [31:0] e_rs2;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_operand(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (bus.ex_fwd_enable && bus.ex_fwd_rd == rs) return bus.ex_fwd_value;
    if (bus.wb_write_enable && bus.wb_rd_sel == rs) return bus.wb_value;
    return mregs[rs];
  endfunction

  function automatic logic m_writes(input logic v, input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return v && (ins[11:7] != 5'd0) &&
           (op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67});
  endfunction

  // Advance one clock: predict from current inputs, then compare every output field
  task automatic cycle();
    logic        n_valid, n_we;
    logic [31:0] n_instr, n_rs1, n_rs2;
    logic [4:0]  n_rd;
    n_valid = e_valid; n_instr = e_instr; n_rd = e_rd; n_we = e_we;
    n_rs1 = e_rs1; n_rs2 = e_rs2;
    if (rst) begin
      n_valid = 0; n_instr = 0; n_rd = 0; n_we = 0; n_rs1 = 0; n_rs2 = 0;
    end else if (bus.flush) begin
      n_valid = 0; n_instr = 32'h13; n_rd = 0; n_we = 0; n_rs1 = 0; n_rs2 = 0;
    end else if (bus.stall) begin
      n_rs1 = m_operand(e_instr[19:15]);
      n_rs2 = m_operand(e_instr[24:20]);
    end else begin
      n_valid = bus.instr_valid;
      n_instr = bus.instr;
      n_rd    = bus.instr[11:7];
      n_we    = m_writes(bus.instr_valid, bus.instr);
      n_rs1   = m_operand(bus.instr[19:15]);
      n_rs2   = m_operand(bus.instr[24:20]);
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (bus.wb_write_enable && bus.wb_rd_sel != 5'd0) begin
      mregs[bus.wb_rd_sel] = bus.wb_value;
    end
    @(posedge clk);
    #1;
    e_valid = n_valid; e_instr = n_instr; e_rd = n_rd; e_we = n_we;
    e_rs1 = n_rs1; e_rs2 = n_rs2;
    check_eq("ex_valid", 32'(bus.ex_valid), 32'(e_valid));
    check_eq("ex_instr", bus.ex_instr, e_instr);
    check_eq("ex_rd_sel", 32'(bus.ex_rd_sel), 32'(e_rd));
    check_eq("ex_write_enable", 32'(bus.ex_write_enable), 32'(e_we));
    check_eq("ex_rs1_value", bus.ex_rs1_value, e_rs1);
    check_eq("ex_rs2_value", bus.ex_rs2_value, e_rs2);
  endtask

  task automatic idle();
    rst = 0;
    bus.instr_valid = 0; bus.instr = 32'd0; bus.stall = 0; bus.flush = 0;
    bus.wb_write_enable = 0; bus.wb_rd_sel = 5'd0; bus.wb_value = 32'd0;
    bus.ex_fwd_enable = 0; bus.ex_fwd_rd = 5'd0; bus.ex_fwd_value = 32'd0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] val);
    bus.wb_write_enable = 1; bus.wb_rd_sel = rd; bus.wb_value = val;
  endtask

  task automatic issue(input logic [31:0] ins);
    bus.instr_valid = 1; bus.instr = ins;
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'b0110011};
  endfunction

  initial begin
    logic [31:0] ins;
    logic [6:0]  ops [10];
    checks = 0; failures = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    ops = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h73};

    // Reset held two cycles
    idle(); rst = 1;
    issue(r_add(5'd3, 5'd1, 5'd2));
    cycle(); cycle();
    check_eq("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("rst_ex_instr", bus.ex_instr, 32'd0);
    idle();

    // Every register reads zero after reset
    for (int k = 1; k < 32; k++) begin
      issue(r_add(5'(k), 5'(k), 5'(32 - k)));
      cycle();
      check_eq("rst_reg_read", bus.ex_rs1_value, 32'd0);
    end

    // Write then read back
    idle(); wb(5'd5, 32'hDEADBEEF); cycle();
    idle(); issue(r_add(5'd6, 5'd5, 5'd0)); cycle();
    check_eq("wr_rs1", bus.ex_rs1_value, 32'hDEADBEEF);
    check_eq("wr_rs2", bus.ex_rs2_value, 32'd0);
    check_eq("wr_rd", 32'(bus.ex_rd_sel), 32'd6);
    check_eq("wr_we", 32'(bus.ex_write_enable), 32'd1);

    // Forwarding priority: execute over write-back over register file
    idle(); wb(5'd7, 32'd1); cycle();
    idle(); wb(5'd7, 32'd2);
    bus.ex_fwd_enable = 1; bus.ex_fwd_rd = 5'd7; bus.ex_fwd_value = 32'd3;
    issue(r_add(5'd8, 5'd7, 5'd7)); cycle();
    check_eq("fwd_ex_rs1", bus.ex_rs1_value, 32'd3);
    check_eq("fwd_ex_rs2", bus.ex_rs2_value, 32'd3);
    bus.ex_fwd_enable = 0; cycle();
    check_eq("fwd_wb_rs1", bus.ex_rs1_value, 32'd2);
    check_eq("fwd_wb_rs2", bus.ex_rs2_value, 32'd2);

    // x0 is never written and never targeted
    idle(); wb(5'd0, 32'hFFFFFFFF); issue(r_add(5'd1, 5'd0, 5'd0)); cycle();
    check_eq("x0_bypass", bus.ex_rs1_value, 32'd0);
    idle(); issue(r_add(5'd1, 5'd0, 5'd0)); cycle();
    check_eq("x0_read", bus.ex_rs2_value, 32'd0);
    issue({12'd1, 5'd0, 3'd0, 5'd0, 7'b0010011}); cycle();
    check_eq("addi_x0_we", 32'(bus.ex_write_enable), 32'd0);
    issue({7'd0, 5'd6, 5'd5, 3'b010, 5'd4, 7'b0100011}); cycle();
    check_eq("store_we", 32'(bus.ex_write_enable), 32'd0);
    check_eq("store_valid", 32'(bus.ex_valid), 32'd1);

    // Stall refresh picks up a write-back landing mid-stall
    idle(); wb(5'd10, 32'd4); cycle();
    idle(); issue(r_add(5'd9, 5'd10, 5'd0)); cycle();
    check_eq("stall_cap_rs1", bus.ex_rs1_value, 32'd4);
    bus.stall = 1; bus.instr = 32'hFFFFFFFF; cycle();
    wb(5'd10, 32'd9); cycle();
    bus.wb_write_enable = 0; cycle();
    check_eq("stall_hold_instr", bus.ex_instr, r_add(5'd9, 5'd10, 5'd0));
    check_eq("stall_refresh_rs1", bus.ex_rs1_value, 32'd9);

    // Flush beats stall
    bus.flush = 1; cycle();
    check_eq("flush_valid", 32'(bus.ex_valid), 32'd0);
    check_eq("flush_we", 32'(bus.ex_write_enable), 32'd0);
    check_eq("flush_instr", bus.ex_instr, 32'h00000013);

    // Reset during a stall clears everything
    idle(); issue(r_add(5'd11, 5'd5, 5'd10)); cycle();
    bus.stall = 1; rst = 1; cycle();
    check_eq("rst_stall_instr", bus.ex_instr, 32'd0);
    idle(); issue(r_add(5'd12, 5'd5, 5'd10)); cycle();
    check_eq("rst_cleared_reg", bus.ex_rs1_value, 32'd0);

    // Random traffic with clustered register indices for frequent hazards
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) != 0) begin
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[11:7]  = 5'($urandom_range(0, 7));
      end
      bus.instr           = ins;
      bus.instr_valid     = ($urandom_range(0, 4) != 0);
      rst                 = ($urandom_range(0, 127) == 0);
      bus.flush           = ($urandom_range(0, 15) == 0);
      bus.stall           = ($urandom_range(0, 3) == 0);
      bus.wb_write_enable = ($urandom_range(0, 1) != 0);
      bus.wb_rd_sel       = 5'(($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      bus.wb_value        = $urandom;
      bus.ex_fwd_enable   = ($urandom_range(0, 2) == 0);
      bus.ex_fwd_rd       = 5'($urandom_range(0, 7));
      bus.ex_fwd_value    = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_reg_decode.md
# pipeline_reg_decode

Decode-to-execute stage of the CMPE 140 RISC-V pipeline. It holds the 32×32 integer register file (2 read ports, 1 write port) and takes the write-back port from the execute pipeline register's outputs. Each cycle it decodes the incoming instruction's register fields and resolves both source operands with forwarding. It then registers the result for the execute stage, with stall and flush control.

## Interface
- XLEN, 32, data width of registers and operands
- NREGS, 32, architectural register count; x0 is hardwired to zero

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  `instr` carries a real instruction this cycle
- instr  in  32  fetched instruction
- stall  in  1  hold the decoded instruction; refresh its operands
- flush  in  1  insert a bubble; priority over `stall`
- wb_write_enable  in  1  write-back enable (execute pipeline register `write_enable_out`)
- wb_rd_sel  in  5  write-back destination (`rd_sel_out`)
- wb_value  in  32  write-back data (`alu_result_out`)
- ex_fwd_enable  in  1  the instruction currently in execute will write a register
- ex_fwd_rd  in  5  destination of that instruction
- ex_fwd_value  in  32  ALU result of that instruction, valid this cycle
- ex_valid  out  1  output bundle holds a real instruction
- ex_instr  out  32  registered instruction
- ex_rd_sel  out  5  `instr[11:7]`
- ex_write_enable  out  1  decoded register-write intent
- ex_rs1_value  out  32  resolved operand for `instr[19:15]`
- ex_rs2_value  out  32  resolved operand for `instr[24:20]`

## Operation
- Decode fields:
  - rs1 = instr[19:15]
  - rs2 = instr[24:20]
  - rd = instr[11:7]
  - opcode = instr[6:0]
- Write intent: `write_enable = instr_valid && rd != 0 && opcode ∈ {0110011 OP, 0010011 OP-IMM, 0000011 LOAD, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR}`. It is 0 for every other opcode (branch, store, system, illegal).
- Register file write: at the rising edge when `wb_write_enable && wb_rd_sel != 0`, `regs[wb_rd_sel] <= wb_value`. Writes to x0 are discarded.
- Operand resolution is combinational and applied independently to rs1 and rs2. Priority, highest first:
  1. rs == 0 → 0.
  2. `ex_fwd_enable && ex_fwd_rd == rs` → `ex_fwd_value`.
  3. `wb_write_enable && wb_rd_sel == rs` → `wb_value` (write-through bypass).
  4. Otherwise → `regs[rs]`.
- Output register update per cycle, priority `rst` > `flush` > `stall` > normal:
  - rst: all outputs 0; all 32 registers cleared to 0.
  - flush: ex_valid=0, ex_write_enable=0, ex_instr=32'h00000013 (NOP); other outputs 0.
  - stall:
    - ex_valid, ex_instr, ex_rd_sel and ex_write_enable hold.
    - ex_rs1_value / ex_rs2_value are re-resolved from the held ex_instr's rs1/rs2 using the same priority. Held operands therefore track write-backs that land during the stall.
    - `instr` is ignored.
  - normal: capture ex_valid=instr_valid, ex_instr=instr, ex_rd_sel=rd, ex_write_enable=write_enable, and both resolved operands.
- When instr_valid=0 in the normal case, ex_valid=0 and ex_write_enable=0. The other fields capture `instr` unconditionally; they are don't-care but deterministic.
- The block does not detect load-use hazards; the upstream control raises `stall`.

## Timing
- Decode→execute latency: 1 cycle. An instruction presented at edge N appears on `ex_*` after edge N+1.
- A register file write is visible to a read after the same edge. The bypass makes it visible in the cycle it is presented.
- Reset is synchronous. `rst` asserted mid-stall or mid-flush wins at that edge, and the register file is cleared at the same edge.
- flush and stall both high: the flush takes effect and the stalled instruction is dropped.
- The outputs are registers only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `rv_pkg`:
  - opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR)
  - NOP encoding 32'h00000013
  - XLEN and NREGS
  - the execute pipeline register reuses the same package.
- One sub-module, `reg_file`:
  - 2 combinational read ports, 1 synchronous write port, synchronous clear on `rst`, x0 reads 0.
  - Forwarding muxes and the output register stay in `pipeline_reg_decode`.

## Test plan
- Reset: hold rst 2 cycles → all `ex_*` = 0. Reading x1..x31 via instructions afterwards yields 0.
- Write/read: wb writes x5=32'hDEADBEEF; the next cycle `add x6,x5,x0` → ex_rs1_value=DEADBEEF, ex_rs2_value=0, ex_rd_sel=6, ex_write_enable=1.
- Forward priority: regs[x7]=1, wb presents x7=2, ex_fwd presents x7=3, `add x8,x7,x7` → both operands = 3. With ex_fwd dropped → 2.
- x0 protection: wb writes x0=32'hFFFFFFFF, then `add x1,x0,x0` → operands 0. Write intent for `addi x0,x0,1` → ex_write_enable=0. A store opcode → ex_write_enable=0.
- Stall refresh: capture `add x9,x10,x0` with x10=4, assert stall 3 cycles, and write x10=9 via wb in stall cycle 2. ex_instr holds and ex_rs1_value becomes 9.
- Flush vs stall: flush=stall=1 with a valid instruction held → ex_valid=0, ex_write_enable=0, ex_instr=32'h00000013.
